iic_reg_seq: RTL

- Transaction sequencer directly upstream of the IIC peripheral's CPU-side register port (CON/CLKDIV/TX/RX at offsets 0-3).
- Turns one request into a full byte sequence: an IIC register write (dev, reg, data) or a register read (dev, reg, repeated-start dev, read byte).
- Drives the peripheral's addr/din/wr_en/rd_en.
- Polls the CON busy bit (bit0) between bytes, so the CPU or a boot-time init ROM issues one request per slave register access.

---
 rtl/iic_reg_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/iic_reg_seq.sv
// iic_reg_seq: turns one register read/write request into the IIC peripheral's CON/CLKDIV/TX/RX byte sequence.
// Define IIC_REG_SEQ_TIMEOUT_EN to add a busy-poll timeout that aborts with a stop and flags err.
module iic_reg_seq #(
  parameter logic [7:0]  CLKDIV_DEFAULT = 8'h20,
  parameter int unsigned POLL_GAP       = 2,
  parameter logic [15:0] TIMEOUT_CYC    = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rnw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic [7:0] clkdiv_i,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       err,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_dout,
  output logic       bus_wr_en,
  output logic       bus_rd_en,
  input  logic [7:0] bus_din
);
  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_LOAD, S_CMD, S_POLL_HI, S_POLL_LO, S_RDRX, S_DONE
  } state_t;
  state_t     state_q;
  logic [1:0] idx_q, idx_d;
  logic       rnw_q, smp_q, ack_q, busy_q, wr_q, rd_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q, rx_q, addr_q, dout_q, tx_d, con_d;
  logic [3:0] gap_q;
  logic       last_d, poll_hit_d, rd_b3_d;
`ifdef IIC_REG_SEQ_TIMEOUT_EN
  logic [15:0] to_q;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign ack       = ack_q;
  assign rdata     = rx_q;
  assign busy      = busy_q;
  assign bus_addr  = addr_q;
  assign bus_dout  = dout_q;
  assign bus_wr_en = wr_q;
  assign bus_rd_en = rd_q;
  // Byte values are formed for the byte about to be issued, which is idx+1 when leaving POLL_LO.
  always_comb begin
    idx_d      = state_q == S_POLL_LO ? idx_q + 2'd1 : idx_q;
    tx_d       = idx_d == 2'd0 ? {dev_q, 1'b0} : idx_d == 2'd1 ? reg_q : rnw_q ? {dev_q, 1'b1} : wdata_q;
    con_d      = {3'b000, rnw_q ? idx_d == 2'd3 : idx_d == 2'd2,
                  idx_d == 2'd0 || (rnw_q && idx_d == 2'd2), rnw_q && idx_d == 2'd3, 2'b00};
    last_d     = idx_q == (rnw_q ? 2'd3 : 2'd2);
    rd_b3_d    = rnw_q && idx_d == 2'd3;
    poll_hit_d = bus_din[0] == (state_q == S_POLL_HI);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      rnw_q   <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
      rx_q    <= 8'h00;
      smp_q   <= 1'b0;
      gap_q   <= 4'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 8'h00;
      dout_q  <= 8'h00;
`ifdef IIC_REG_SEQ_TIMEOUT_EN
      to_q    <= 16'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 8'h00;
      dout_q <= 8'h00;
      ack_q  <= 1'b0;
`ifdef IIC_REG_SEQ_TIMEOUT_EN
      to_q   <= 16'd0;
`endif
      case (state_q)
        S_IDLE: if (req) begin
          rnw_q   <= rnw;
          dev_q   <= dev_addr;
          reg_q   <= reg_addr;
          wdata_q <= wdata;
          idx_q   <= 2'd0;
          busy_q  <= 1'b1;
`ifdef IIC_REG_SEQ_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          wr_q    <= 1'b1;
          addr_q  <= 8'h01;
          dout_q  <= clkdiv_i == 8'h00 ? CLKDIV_DEFAULT : clkdiv_i;
          state_q <= S_CFG;
        end
        S_CFG: begin
          wr_q    <= 1'b1;
          addr_q  <= 8'h02;
          dout_q  <= tx_d;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          wr_q    <= 1'b1;
          dout_q  <= con_d;
          state_q <= S_CMD;
        end
        S_CMD: begin
          rd_q    <= 1'b1;
          smp_q   <= 1'b0;
          gap_q   <= 4'd0;
          state_q <= S_POLL_HI;
        end
        // Poll phases: rd cycle, sample cycle (bus_din valid), then POLL_GAP idle cycles.
        S_POLL_HI, S_POLL_LO: begin
`ifdef IIC_REG_SEQ_TIMEOUT_EN
          to_q <= to_q + 16'd1;
          if (to_q == TIMEOUT_CYC) begin
            wr_q    <= 1'b1;
            dout_q  <= 8'h10;
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            smp_q   <= 1'b0;
            gap_q   <= 4'd0;
            state_q <= S_DONE;
          end else
`endif
          if (gap_q != 4'd0) begin
            gap_q <= gap_q - 4'd1;
            rd_q  <= gap_q == 4'd1;
          end else if (!smp_q) smp_q <= 1'b1;
          else begin
            smp_q <= 1'b0;
            if (!poll_hit_d) begin
              gap_q <= 4'(POLL_GAP);
              rd_q  <= POLL_GAP == 0;
            end else if (state_q == S_POLL_HI) begin
`ifdef IIC_REG_SEQ_TIMEOUT_EN
              to_q    <= 16'd0;
`endif
              rd_q    <= 1'b1;
              state_q <= S_POLL_LO;
            end else if (!last_d) begin
              idx_q   <= idx_d;
              wr_q    <= 1'b1;
              addr_q  <= rd_b3_d ? 8'h00 : 8'h02;
              dout_q  <= rd_b3_d ? con_d : tx_d;
              state_q <= rd_b3_d ? S_CMD : S_LOAD;
            end else if (rnw_q) begin
              rd_q    <= 1'b1;
              addr_q  <= 8'h03;
              state_q <= S_RDRX;
            end else begin
              ack_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RDRX: if (!smp_q) smp_q <= 1'b1;
        else begin
          smp_q   <= 1'b0;
          rx_q    <= bus_din;
          ack_q   <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
